// File: rtl/penc_rr_arb_16.sv
// rtl/penc_rr_arb_16.sv - sixteen-requester round-robin arbiter with hold-limit watchdog
module penc_rr_arb_16 #(
    parameter int unsigned MAX_HOLD = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] req,
    input  logic        done,
    output logic        gnt_val,
    output logic [3:0]  gnt_idx,
    output logic [15:0] gnt_oh,
    output logic        timeout
);

    localparam logic IDLE = 1'b0;
    localparam logic BUSY = 1'b1;

    localparam bit          WD_EN     = (MAX_HOLD != 0);
    localparam logic [15:0] HOLD_LAST = (MAX_HOLD == 0) ? 16'd0 : 16'(MAX_HOLD - 1);

    logic        state_q, state_d;
    logic [3:0]  ptr_q, ptr_d;
    logic [15:0] hold_cnt_q, hold_cnt_d;
    logic [3:0]  gnt_idx_q, gnt_idx_d;
    logic [15:0] gnt_oh_q, gnt_oh_d;
    logic        timeout_q, timeout_d;

    logic        win_any;
    logic [3:0]  win_idx;
    logic [3:0]  cand;
    logic        wd_hit;

    // Scan from the highest offset down so the nearest request at/after ptr is the last one to stick.
    always_comb begin
        win_any = 1'b0;
        win_idx = ptr_q;
        cand    = ptr_q;
        for (int i = 15; i >= 0; i--) begin
            cand = ptr_q + 4'(i);
            if (req[cand]) begin
                win_any = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign wd_hit = WD_EN && (hold_cnt_q == HOLD_LAST) && !done;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        gnt_idx_d  = gnt_idx_q;
        gnt_oh_d   = gnt_oh_q;
        timeout_d  = 1'b0;
        if (state_q == IDLE) begin
            if (win_any) begin
                state_d    = BUSY;
                gnt_idx_d  = win_idx;
                gnt_oh_d   = 16'b1 << win_idx;
                ptr_d      = win_idx + 4'd1;
                hold_cnt_d = 16'd0;
            end
        end else begin
            hold_cnt_d = (hold_cnt_q == 16'hFFFF) ? hold_cnt_q : hold_cnt_q + 16'd1;
            if (done || wd_hit) begin
                timeout_d = wd_hit;
                if (win_any) begin
                    gnt_idx_d  = win_idx;
                    gnt_oh_d   = 16'b1 << win_idx;
                    ptr_d      = win_idx + 4'd1;
                    hold_cnt_d = 16'd0;
                end else begin
                    state_d  = IDLE;
                    gnt_oh_d = 16'd0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            ptr_q      <= 4'd0;
            hold_cnt_q <= 16'd0;
            gnt_idx_q  <= 4'd0;
            gnt_oh_q   <= 16'd0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_idx_q  <= gnt_idx_d;
            gnt_oh_q   <= gnt_oh_d;
            timeout_q  <= timeout_d;
        end
    end

    assign gnt_val = (state_q == BUSY);
    assign gnt_idx = gnt_idx_q;
    assign gnt_oh  = gnt_oh_q;
    assign timeout = timeout_q;

endmodule
